// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/flow control for a five-stage MIPS pipeline: load-use stalls, taken-branch
// flushes, per-latch valid tracking, single-step execution and HALT drain.
module pipeline_hazard_ctrl #(
  parameter int unsigned W  = 5,
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step_mode,
  input  logic          step,
  input  logic          halt_id,
  input  logic [W-1:0]  rs_id,
  input  logic [W-1:0]  rt_id,
  input  logic          memread_idex,
  input  logic [W-1:0]  rt_idex,
  input  logic          taken_mem,
  output logic          pc_write,
  output logic          ifid_write,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic          exmem_flush,
  output logic          advance,
  output logic [3:0]    valid,
  output logic          halted,
  output logic [CW-1:0] cycle_count,
  output logic [CW-1:0] stall_count
);

  typedef enum logic [1:0] {StRun, StStepIdle, StDrain, StHalted} state_e;

  state_e        state_q, state_d;
  logic [3:0]    valid_q, valid_d;
  logic [2:0]    hpos_q, hpos_d;
  logic          halted_q;
  logic [CW-1:0] cycle_q, stall_q;

  logic taken, stall_raw, stall, halt_go, draining;

  assign draining  = (state_q == StDrain);
  assign taken     = taken_mem & valid_q[2];
  assign stall_raw = memread_idex & valid_q[1] & valid_q[0] & (rt_idex != '0) &
                     ((rt_idex == rs_id) | (rt_idex == rt_id));
  assign stall     = stall_raw & ~taken;

  always_comb begin
    advance = 1'b0;
    unique case (state_q)
      StRun:      advance = 1'b1;
      StStepIdle: advance = step & step_mode;
      StDrain:    advance = step_mode ? step : 1'b1;
      StHalted:   advance = 1'b0;
      default:    advance = 1'b0;
    endcase
  end

  // A stalled HALT stays in IF_ID and is seen again once the stall clears.
  assign halt_go = halt_id & valid_q[0] & advance & ~taken_mem & ~stall_raw &
                   ((state_q == StRun) | (state_q == StStepIdle));

  assign pc_write    = advance & (taken | (~stall & ~halt_go & ~draining));
  assign ifid_write  = advance & ~stall;
  assign ifid_flush  = taken | draining;
  assign idex_flush  = taken | stall;
  assign exmem_flush = taken;

  always_comb begin
    valid_d = valid_q;
    hpos_d  = hpos_q;
    if (advance) begin
      valid_d[3] = valid_q[2];
      valid_d[2] = valid_q[1] & ~taken;
      valid_d[1] = valid_q[0] & ~taken & ~stall;
      valid_d[0] = stall ? valid_q[0] : pc_write;
      // A taken branch in EX_MEM kills whatever sits in IF_ID and ID_EX.
      hpos_d     = {hpos_q[1], hpos_q[0] & ~taken, halt_go};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (halt_go)        state_d = StDrain;
        else if (step_mode) state_d = StStepIdle;
      end
      StStepIdle: begin
        if (halt_go)         state_d = StDrain;
        else if (!step_mode) state_d = StRun;
      end
      StDrain: begin
        if (advance) begin
          if (hpos_q[2])           state_d = StHalted;
          else if (hpos_d == '0)   state_d = step_mode ? StStepIdle : StRun;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= step_mode ? StStepIdle : StRun;
      valid_q  <= '0;
      hpos_q   <= '0;
      halted_q <= 1'b0;
      cycle_q  <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      hpos_q   <= hpos_d;
      halted_q <= (state_d == StHalted);
      if (advance)         cycle_q <= cycle_q + CW'(1);
      if (advance & stall) stall_q <= stall_q + CW'(1);
    end
  end

  assign valid       = valid_q;
  assign halted      = halted_q;
  assign cycle_count = cycle_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl against a stage-occupancy model.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset, step_mode, step, halt_id, memread_idex, taken_mem;
  logic [4:0]  rs_id, rt_id, rt_idex;
  logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, advance, halted;
  logic [3:0]  valid;
  logic [31:0] cycle_count, stall_count;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.W(5), .CW(32)) dut (
    .clk(clk), .reset(reset), .step_mode(step_mode), .step(step), .halt_id(halt_id),
    .rs_id(rs_id), .rt_id(rt_id), .memread_idex(memread_idex), .rt_idex(rt_idex),
    .taken_mem(taken_mem), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .advance(advance), .valid(valid), .halted(halted), .cycle_count(cycle_count),
    .stall_count(stall_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: occupancy per latch, which latch holds the HALT (0 = none, 1 = ID_EX .. 3 = MEM_WB),
  // whether the last cycle requested single-step, and the two event counts.
  bit [3:0]    m_valid;
  int          m_halt_at;
  bit          m_halted, m_in_step;
  logic [31:0] m_cyc, m_stl;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input bit rst, input bit sm, input bit st, input bit hid,
                     input logic [4:0] rs, input logic [4:0] rt, input bit mr,
                     input logic [4:0] rti, input bit tk);
    bit tk_eff, ld, adv, hgo, pcw, n_halted;
    bit [3:0] nv;
    int nh;
    @(negedge clk);
    reset = rst; step_mode = sm; step = st; halt_id = hid; rs_id = rs; rt_id = rt;
    memread_idex = mr; rt_idex = rti; taken_mem = tk;
    #1;
    nv = m_valid; nh = m_halt_at; n_halted = m_halted;
    if (!rst) begin
      tk_eff = tk && m_valid[2];
      ld  = mr && m_valid[1] && m_valid[0] && rti != 0 && (rti == rs || rti == rt) && !tk_eff;
      if (m_halted)          adv = 0;
      else if (m_halt_at != 0) adv = sm ? st : 1'b1;
      else if (m_in_step)    adv = st && sm;
      else                   adv = 1;
      hgo = m_halt_at == 0 && !m_halted && hid && m_valid[0] && adv && !tk && !ld;
      pcw = adv && (tk_eff || (!ld && !hgo && m_halt_at == 0));
      check_eq("advance", advance, adv);
      check_eq("pc_write", pc_write, pcw);
      check_eq("ifid_write", ifid_write, adv && !ld);
      if (adv) begin
        check_eq("ifid_flush", ifid_flush, tk_eff || m_halt_at != 0);
        check_eq("idex_flush", idex_flush, tk_eff || ld);
        check_eq("exmem_flush", exmem_flush, tk_eff);
      end
      if (adv) begin
        nv[3] = m_valid[2];
        nv[2] = tk_eff ? 1'b0 : m_valid[1];
        nv[1] = (tk_eff || ld) ? 1'b0 : m_valid[0];
        nv[0] = ld ? m_valid[0] : pcw;
        if (hgo) nh = 1;
        else if (m_halt_at == 1 && tk_eff) nh = 0;
        else if (m_halt_at == 3) begin nh = 0; n_halted = 1; end
        else if (m_halt_at > 0) nh = m_halt_at + 1;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_halt_at = 0; m_halted = 0; m_cyc = 0; m_stl = 0;
    end else begin
      if (adv) m_cyc = m_cyc + 1;
      if (adv && ld) m_stl = m_stl + 1;
      m_valid = nv; m_halt_at = nh; m_halted = n_halted;
    end
    m_in_step = sm;
    check_eq("valid", valid, m_valid);
    check_eq("halted", halted, m_halted);
    check_eq("cycle_count", cycle_count, m_cyc);
    check_eq("stall_count", stall_count, m_stl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit sm_r;
    int halted_run;
    {reset, step_mode, step, halt_id, memread_idex, taken_mem} = '0;
    {rs_id, rt_id, rt_idex} = '0;
    m_valid = 0; m_halt_at = 0; m_halted = 0; m_in_step = 0; m_cyc = 0; m_stl = 0;

    // Free-run fill.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("rst_valid", valid, 4'b0000);
    check_eq("rst_cycles", cycle_count, 32'd0);
    idle(10);
    check_eq("fill_valid", valid, 4'b1111);
    check_eq("fill_cycles", cycle_count, 32'd10);
    check_eq("fill_stalls", stall_count, 32'd0);

    // Load-use stall, then the same with $0 as destination.
    cyc(0, 0, 0, 0, 5'd2, 5'd7, 1, 5'd2, 0);
    check_eq("stall_once", stall_count, 32'd1);
    cyc(0, 0, 0, 0, 5'd0, 5'd7, 1, 5'd0, 0);
    check_eq("no_stall_r0", stall_count, 32'd1);

    // Taken branch beats a concurrent stall.
    idle(2);
    cyc(0, 0, 0, 0, 5'd3, 5'd3, 1, 5'd3, 1);
    check_eq("taken_valid", valid, 4'b1001);
    check_eq("taken_nostall", stall_count, 32'd1);

    // HALT drains in four advances.
    idle(4);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(2);
    check_eq("not_yet_halted", halted, 1'b0);
    idle(1);
    check_eq("halted", halted, 1'b1);
    idle(3);

    // HALT in ID_EX killed by an older taken branch.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(6);
    check_eq("halt_killed", halted, 1'b0);

    // Single-step: three pulses.
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    end
    check_eq("step_cycles", cycle_count, 32'd3);

    // Reset in the middle of a drain.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("mid_drain_valid", valid, 4'b0000);
    check_eq("mid_drain_cycles", cycle_count, 32'd0);
    check_eq("mid_drain_halted", halted, 1'b0);

    // Random traffic.
    sm_r = 0;
    halted_run = 0;
    for (int i = 0; i < 3000; i++) begin
      bit rst_r;
      if ($urandom_range(49) == 0) sm_r = ~sm_r;
      halted_run = m_halted ? halted_run + 1 : 0;
      rst_r = ($urandom_range(299) == 0) || (halted_run > 4);
      cyc(rst_r, sm_r, ($urandom_range(2) == 0), ($urandom_range(29) == 0),
          5'($urandom_range(3)), 5'($urandom_range(3)), ($urandom_range(2) == 0),
          5'($urandom_range(3)), ($urandom_range(7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
